// File: rtl/alu_uart_interface.sv
// Serial front end for the ALU: gathers A, B and opcode bytes from the UART, computes, sends the result byte.
// Optional INTF_TIMEOUT_EN adds an inter-byte timeout that abandons a partial sequence.
module alu_uart_interface #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic               o_op_error,
  output logic               o_rx_overrun
);

  typedef enum logic [2:0] {IDLE, WAIT_B, WAIT_OP, CALC, SEND, WAIT_TX} state_e;

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic               tx_start_q, tx_start_d;
  logic               op_error_q, op_error_d;
  logic               rx_overrun_q, rx_overrun_d;
  logic               op_valid;

`ifdef INTF_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout;
`endif

  // Upper opcode bits must be zero; the low bits must name a supported operation.
  always_comb begin
    op_valid = 1'b0;
    if (i_rx_data[NB_DATA-1:NB_OP] == '0) begin
      case (i_rx_data[NB_OP-1:0])
        NB_OP'(8'h20), NB_OP'(8'h22), NB_OP'(8'h24), NB_OP'(8'h25),
        NB_OP'(8'h26), NB_OP'(8'h03), NB_OP'(8'h02), NB_OP'(8'h27): op_valid = 1'b1;
        default: op_valid = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    op_error_d   = 1'b0;
    rx_overrun_d = rx_overrun_q;
`ifdef INTF_TIMEOUT_EN
    cnt_d   = '0;
    timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
    case (state_q)
      IDLE: begin
        if (i_rx_done) begin
          alu_a_d = i_rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_done) begin
          alu_b_d = i_rx_data;
          state_d = WAIT_OP;
        end
`ifdef INTF_TIMEOUT_EN
        else if (timeout) state_d = IDLE;
        else              cnt_d   = cnt_q + 1'b1;
`endif
      end
      WAIT_OP: begin
        if (i_rx_done) begin
          if (op_valid) begin
            alu_op_d = i_rx_data[NB_OP-1:0];
            state_d  = CALC;
          end else begin
            op_error_d = 1'b1;
            state_d    = IDLE;
          end
        end
`ifdef INTF_TIMEOUT_EN
        else if (timeout) state_d = IDLE;
        else              cnt_d   = cnt_q + 1'b1;
`endif
      end
      CALC: begin
        tx_data_d = i_alu_result;
        state_d   = SEND;
      end
      SEND: begin
        if (!i_tx_busy) begin
          tx_start_d = 1'b1;
          state_d    = WAIT_TX;
        end
      end
      WAIT_TX: begin
        if (i_tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Bytes arriving while the result is being produced or sent are lost.
    if (i_rx_done && (state_q inside {CALC, SEND, WAIT_TX})) rx_overrun_d = 1'b1;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      op_error_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
`ifdef INTF_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      op_error_q   <= op_error_d;
      rx_overrun_q <= rx_overrun_d;
`ifdef INTF_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign o_alu_a      = alu_a_q;
  assign o_alu_b      = alu_b_q;
  assign o_alu_op     = alu_op_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_start   = tx_start_q;
  assign o_op_error   = op_error_q;
  assign o_rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Scoreboard bench for alu_uart_interface: stimulus pushes expected tx bytes / error pulses, a monitor pops and compares.
module tb_alu_uart_interface;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_done = 1'b0;
  logic       tx_busy_force = 1'b0;
  logic       tx_busy_model = 1'b0;
  logic       tx_busy;
  logic       tx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] alu_res, alu_a, alu_b;
  logic [5:0] alu_op;
  logic       op_error, rx_overrun;

  int unsigned cyc = 0;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int          tx_cnt = 0;
  logic [7:0]  last_sent = '0;

  typedef struct {
    bit          err;
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;
  exp_t exp_q[$];

  assign tx_busy = tx_busy_force | tx_busy_model;

  alu_uart_interface #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(16)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_busy(tx_busy), .i_tx_done(tx_done),
    .o_tx_data(tx_data), .o_tx_start(tx_start),
    .i_alu_result(alu_res),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .o_op_error(op_error), .o_rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference ALU attached to the operand outputs
  always_comb begin
    case (alu_op)
      6'h20:   alu_res = alu_a + alu_b;
      6'h22:   alu_res = alu_a - alu_b;
      6'h24:   alu_res = alu_a & alu_b;
      6'h25:   alu_res = alu_a | alu_b;
      6'h26:   alu_res = alu_a ^ alu_b;
      6'h03:   alu_res = $signed(alu_a) >>> alu_b;
      6'h02:   alu_res = alu_a >> alu_b;
      6'h27:   alu_res = ~(alu_a | alu_b);
      default: alu_res = '0;
    endcase
  end

  // Transmitter model: busy for a few cycles after a start, then a done pulse
  always @(negedge clk) begin
    tx_done <= 1'b0;
    if (!rst_n) begin
      tx_cnt        <= 0;
      tx_busy_model <= 1'b0;
    end else if (tx_start) begin
      tx_busy_model <= 1'b1;
      tx_cnt        <= 4;
    end else if (tx_cnt > 1) begin
      tx_cnt <= tx_cnt - 1;
    end else if (tx_cnt == 1) begin
      tx_cnt        <= 0;
      tx_done       <= 1'b1;
      tx_busy_model <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start || op_error) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {30'd0, tx_start, op_error}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("event_kind", {30'd0, tx_start, op_error}, e.err ? 32'd1 : 32'd2);
          check("event_cycle", cyc, e.cyc);
          if (!e.err) begin
            check("tx_data", {24'd0, tx_data}, {24'd0, e.data});
            last_sent = tx_data;
          end
        end
      end
      if (tx_done) check("tx_data_held", {24'd0, tx_data}, {24'd0, last_sent});
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Expected event cycle is taken one negedge before the opcode edge
  task automatic run_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input bit err, input logic [7:0] exp_data, input int unsigned busy_extra);
    exp_t e;
    send_byte(a);
    send_byte(b);
    @(negedge clk);
    e.err  = err;
    e.data = exp_data;
    e.cyc  = err ? cyc + 1 : cyc + 3 + busy_extra;
    exp_q.push_back(e);
    rx_data = op;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    #12;
    check("rst_alu_a", {24'd0, alu_a}, 32'd0);
    check("rst_alu_b", {24'd0, alu_b}, 32'd0);
    check("rst_alu_op", {26'd0, alu_op}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_op_error", {31'd0, op_error}, 32'd0);
    check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_seq(8'h05, 8'h03, 8'h20, 1'b0, 8'h08, 0);
    repeat (12) @(negedge clk);
    check("hold_alu_a", {24'd0, alu_a}, 32'h05);
    check("hold_alu_b", {24'd0, alu_b}, 32'h03);
    check("hold_alu_op", {26'd0, alu_op}, 32'h20);
    run_seq(8'h03, 8'h05, 8'h22, 1'b0, 8'hFE, 0);
    repeat (12) @(negedge clk);
    run_seq(8'h80, 8'h02, 8'h03, 1'b0, 8'hE0, 0);
    repeat (12) @(negedge clk);
    run_seq(8'h80, 8'h02, 8'h02, 1'b0, 8'h20, 0);
    repeat (12) @(negedge clk);
    run_seq(8'h0F, 8'hF0, 8'h27, 1'b0, 8'h00, 0);
    repeat (12) @(negedge clk);
    run_seq(8'h01, 8'h02, 8'h15, 1'b1, 8'h00, 0);
    repeat (12) @(negedge clk);
    check("op_unchanged_on_error", {26'd0, alu_op}, 32'h27);
    run_seq(8'h01, 8'h02, 8'h65, 1'b1, 8'h00, 0);
    repeat (12) @(negedge clk);
    run_seq(8'h01, 8'h02, 8'h25, 1'b0, 8'h03, 0);
    repeat (12) @(negedge clk);
    check("no_overrun_yet", {31'd0, rx_overrun}, 32'd0);

    // Transmitter busy for 20 cycles, then an extra byte while waiting for tx done
    tx_busy_force = 1'b1;
    run_seq(8'h05, 8'h03, 8'h20, 1'b0, 8'h08, 19);
    repeat (20) @(negedge clk);
    tx_busy_force = 1'b0;
    @(negedge clk);
    send_byte(8'hAA);
    check("overrun_set", {31'd0, rx_overrun}, 32'd1);
    repeat (12) @(negedge clk);
    run_seq(8'h06, 8'h03, 8'h26, 1'b0, 8'h05, 0);
    repeat (12) @(negedge clk);
    check("overrun_sticky", {31'd0, rx_overrun}, 32'd1);
    check("accepted_a_after_overrun", {24'd0, alu_a}, 32'h06);

    // Reset in the middle of a sequence
    send_byte(8'h44);
    send_byte(8'h55);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_alu_a", {24'd0, alu_a}, 32'd0);
    check("midrst_alu_b", {24'd0, alu_b}, 32'd0);
    check("midrst_alu_op", {26'd0, alu_op}, 32'd0);
    check("midrst_tx_data", {24'd0, tx_data}, 32'd0);
    check("midrst_overrun", {31'd0, rx_overrun}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_seq(8'h07, 8'h01, 8'h24, 1'b0, 8'h01, 0);
    repeat (12) @(negedge clk);
    check("post_rst_alu_a", {24'd0, alu_a}, 32'h07);

`ifdef INTF_TIMEOUT_EN
    send_byte(8'h11);
    repeat (16) @(negedge clk);
    run_seq(8'h02, 8'h03, 8'h20, 1'b0, 8'h05, 0);
    repeat (12) @(negedge clk);
    check("timeout_alu_a", {24'd0, alu_a}, 32'h02);
    check("timeout_alu_b", {24'd0, alu_b}, 32'h03);
`endif

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
